// File: rtl/enemy_ai_keygen_if.sv
// Keycode link between the CPU tank's AI source and the rest of the top level.
// master drives the tank/target observations, slave (the AI) returns keycode and debug state.
interface enemy_ai_keygen_if;
    logic       frame_clk;
    logic       ai_en;
    logic [9:0] self_X;
    logic [9:0] self_Y;
    logic [9:0] target_X;
    logic [9:0] target_Y;
    logic [2:0] self_dir;
    logic [1:0] self_hit;
    logic [7:0] keycode;
    logic [2:0] ai_state;

    modport master (
        output frame_clk, ai_en, self_X, self_Y, target_X, target_Y, self_dir, self_hit,
        input  keycode, ai_state
    );

    modport slave (
        input  frame_clk, ai_en, self_X, self_Y, target_X, target_Y, self_dir, self_hit,
        output keycode, ai_state
    );
endinterface

// File: rtl/enemy_ai_keygen.sv
// Per-frame keycode generator that chases, aligns with, turns toward and shoots the player tank.
// Optional wander moves in IDLE/COOLDOWN are enabled with ENEMY_AI_WANDER_EN.
module enemy_ai_keygen #(
    parameter int          IDLE_FRAMES     = 30,
    parameter int          COOLDOWN_FRAMES = 60,
    parameter int          FIRE_FRAMES     = 2,
    parameter int          ALIGN_TOL       = 4,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input logic               Clk,
    input logic               Reset,
    enemy_ai_keygen_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEEK = 3'd1,
        S_AIM  = 3'd2,
        S_FIRE = 3'd3,
        S_COOL = 3'd4
    } state_e;

    localparam logic [7:0] K_NONE  = 8'h00;
    localparam logic [7:0] K_UP    = 8'h1A;
    localparam logic [7:0] K_RIGHT = 8'h07;
    localparam logic [7:0] K_LEFT  = 8'h04;
    localparam logic [7:0] K_DOWN  = 8'h16;
    localparam logic [7:0] K_FIRE  = 8'h2C;

    localparam logic [7:0] IDLE_LAST = 8'(IDLE_FRAMES - 1);
    localparam logic [7:0] COOL_LAST = 8'(COOLDOWN_FRAMES - 1);
    localparam logic [7:0] FIRE_LAST = 8'(FIRE_FRAMES - 1);
    localparam logic [9:0] TOL       = 10'(ALIGN_TOL);

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [7:0] key_q;
    logic       fr1_q, fr2_q;
    logic       pulse;

    // frame_clk is unrelated to Clk; the first flop resynchronises, the second gives the edge
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fr1_q <= 1'b0;
            fr2_q <= 1'b0;
        end else begin
            fr1_q <= bus.frame_clk;
            fr2_q <= fr1_q;
        end
    end
    assign pulse = fr1_q & ~fr2_q;

    logic [10:0] dx, dy, ndx, ndy;
    logic [9:0]  adx, ady;
    logic        col_al, row_al;
    logic [2:0]  req_dir;
    logic [7:0]  seek_key;

    function automatic logic [7:0] dir_key(input logic [2:0] d);
        case (d)
            3'd1:    dir_key = K_UP;
            3'd2:    dir_key = K_RIGHT;
            3'd3:    dir_key = K_LEFT;
            default: dir_key = K_DOWN;
        endcase
    endfunction

    always_comb begin
        dx     = {1'b0, bus.target_X} - {1'b0, bus.self_X};
        dy     = {1'b0, bus.target_Y} - {1'b0, bus.self_Y};
        ndx    = -dx;
        ndy    = -dy;
        adx    = dx[10] ? ndx[9:0] : dx[9:0];
        ady    = dy[10] ? ndy[9:0] : dy[9:0];
        col_al = (adx <= TOL);
        row_al = (ady <= TOL);
        // column alignment wins, so a coincident target is shot facing down
        if (col_al)
            req_dir = dy[10] ? 3'd1 : 3'd4;
        else
            req_dir = dx[10] ? 3'd3 : 3'd2;
        // close the shorter gap first; equal gaps move along X
        if (adx <= ady)
            seek_key = dx[10] ? K_LEFT : K_RIGHT;
        else
            seek_key = dy[10] ? K_UP : K_DOWN;
    end

    logic [7:0] idle_key, cool_key;

`ifdef ENEMY_AI_WANDER_EN
    logic [15:0] lfsr_q, lfsr_d;

    function automatic logic [7:0] wander_key(input logic [1:0] sel);
        case (sel)
            2'd0:    wander_key = K_UP;
            2'd1:    wander_key = K_RIGHT;
            2'd2:    wander_key = K_DOWN;
            default: wander_key = K_LEFT;
        endcase
    endfunction

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)      lfsr_q <= LFSR_SEED;
        else if (pulse) lfsr_q <= lfsr_d;
    end

    assign idle_key = wander_key(lfsr_q[1:0]);
    assign cool_key = (lfsr_q[3:0] == 4'd0) ? wander_key(lfsr_q[5:4]) : K_NONE;
`else
    logic [15:0] seed_unused;
    assign seed_unused = LFSR_SEED;
    assign idle_key    = K_NONE;
    assign cool_key    = K_NONE;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            key_q   <= K_NONE;
        end else if (!bus.ai_en) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            key_q   <= K_NONE;
        end else begin
            case (state_q)
                S_IDLE: if (pulse) begin
                    key_q <= idle_key;
                    if (cnt_q == IDLE_LAST) begin
                        state_q <= S_SEEK;
                        cnt_q   <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_SEEK: if (pulse) begin
                    if (col_al || row_al) begin
                        state_q <= S_AIM;
                        cnt_q   <= 8'd0;
                        key_q   <= K_NONE;
                    end else begin
                        key_q <= seek_key;
                    end
                end
                S_AIM: if (pulse) begin
                    if (!col_al && !row_al) begin
                        state_q <= S_SEEK;
                        cnt_q   <= 8'd0;
                        key_q   <= K_NONE;
                    end else if (bus.self_dir == req_dir) begin
                        state_q <= S_FIRE;
                        cnt_q   <= 8'd0;
                        key_q   <= K_FIRE;
                    end else begin
                        key_q <= dir_key(req_dir);
                    end
                end
                // a bullet already in flight (even a stale one) ends the attempt
                S_FIRE: if (pulse) begin
                    if (bus.self_hit != 2'b00 || cnt_q >= FIRE_LAST) begin
                        state_q <= S_COOL;
                        cnt_q   <= 8'd0;
                        key_q   <= K_NONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        key_q <= K_FIRE;
                    end
                end
                S_COOL: if (pulse) begin
                    key_q <= cool_key;
                    if (cnt_q == COOL_LAST) begin
                        state_q <= S_SEEK;
                        cnt_q   <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 8'd0;
                    key_q   <= K_NONE;
                end
            endcase
        end
    end

    assign bus.keycode  = key_q;
    assign bus.ai_state = state_q;

endmodule

// File: tb/tb_enemy_ai_keygen.sv
// Directed bench for enemy_ai_keygen: vector table for the per-frame FSM plus
// hand sequences for disable, async reset, frame-edge discipline and the wander LFSR.
module tb_enemy_ai_keygen;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #10 Clk = ~Clk;

    enemy_ai_keygen_if bus();

    enemy_ai_keygen dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

`ifdef ENEMY_AI_WANDER_EN
    localparam bit WANDER = 1'b1;
`else
    localparam bit WANDER = 1'b0;
`endif

    typedef struct {
        int         nfr;
        logic [9:0] sx, sy, tx, ty;
        logic [2:0] dir;
        logic [1:0] hit;
        logic [7:0] key;
        logic [2:0] st;
    } vec_t;

    vec_t tbl[$];
    int   ntests = 0;
    int   nfail  = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // IDLE/COOLDOWN keys are random when wandering, so only state is checked there
    task automatic chk_out(input string nm, input logic [7:0] key, input logic [2:0] st);
        chk({nm, ".state"}, {5'd0, bus.ai_state}, {5'd0, st});
        if (!(WANDER && (st == 3'd0 || st == 3'd4)))
            chk({nm, ".key"}, bus.keycode, key);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk) bus.frame_clk = 1'b1;
            repeat (3) @(negedge Clk);
            bus.frame_clk = 1'b0;
            repeat (3) @(negedge Clk);
        end
    endtask

    task automatic set_pos(input logic [9:0] sx, sy, tx, ty, input logic [2:0] dir, input logic [1:0] hit);
        bus.self_X = sx; bus.self_Y = sy; bus.target_X = tx; bus.target_Y = ty;
        bus.self_dir = dir; bus.self_hit = hit;
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] m);
        return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    endfunction

    function automatic logic [7:0] wkey(input logic [1:0] s);
        case (s)
            2'd0:    return 8'h1A;
            2'd1:    return 8'h07;
            2'd2:    return 8'h16;
            default: return 8'h04;
        endcase
    endfunction

    initial begin
        bus.frame_clk = 1'b0;
        bus.ai_en     = 1'b1;
        set_pos(10'd100, 10'd100, 10'd300, 10'd150, 3'd1, 2'd0);

        //            nfr  sx   sy   tx   ty  dir hit  key   st
        tbl.push_back('{29, 100, 100, 300, 150, 1, 0, 8'h00, 0}); // idle counting
        tbl.push_back('{1,  100, 100, 300, 150, 1, 0, 8'h00, 1}); // pulse 30 -> SEEK
        tbl.push_back('{1,  100, 100, 300, 150, 1, 0, 8'h16, 1}); // |dy| smaller, down
        tbl.push_back('{1,  100, 100, 120, 400, 1, 0, 8'h07, 1}); // |dx| smaller, right
        tbl.push_back('{1,  300, 300, 100, 290, 1, 0, 8'h1A, 1}); // dy<0, up
        tbl.push_back('{1,  300, 300, 290, 100, 1, 0, 8'h04, 1}); // dx<0, left
        tbl.push_back('{1,  100, 100, 150, 150, 1, 0, 8'h07, 1}); // tie -> X
        tbl.push_back('{1,  100, 100, 105, 300, 1, 0, 8'h07, 1}); // |dx|=5 not aligned
        tbl.push_back('{1,  200, 100, 202, 300, 1, 0, 8'h00, 2}); // column aligned -> AIM
        tbl.push_back('{1,  200, 100, 202, 300, 1, 0, 8'h16, 2}); // need down, facing up
        tbl.push_back('{1,  200, 100, 202, 300, 4, 0, 8'h2C, 3}); // facing down -> FIRE
        tbl.push_back('{1,  200, 100, 202, 300, 4, 0, 8'h2C, 3}); // second fire frame
        tbl.push_back('{1,  200, 100, 202, 300, 4, 0, 8'h00, 4}); // FIRE_FRAMES reached
        tbl.push_back('{59, 200, 100, 202, 300, 4, 0, 8'h00, 4}); // still cooling
        tbl.push_back('{1,  200, 100, 202, 300, 4, 0, 8'h00, 1}); // pulse 60 -> SEEK
        tbl.push_back('{1,  200, 100, 204, 100, 2, 0, 8'h00, 2}); // |dx|=4 inclusive
        tbl.push_back('{1,  200, 100, 204, 100, 2, 0, 8'h16, 2}); // dy=0 -> down
        tbl.push_back('{1,  200, 100, 300, 103, 2, 0, 8'h2C, 3}); // row aligned, right
        tbl.push_back('{1,  200, 100, 300, 103, 2, 1, 8'h00, 4}); // bullet out -> COOLDOWN
        tbl.push_back('{59, 200, 100, 300, 103, 2, 0, 8'h00, 4});
        tbl.push_back('{1,  200, 100, 300, 103, 2, 0, 8'h00, 1});
        tbl.push_back('{1,  300, 100, 100, 102, 2, 0, 8'h00, 2}); // row aligned
        tbl.push_back('{1,  300, 100, 100, 102, 2, 0, 8'h04, 2}); // need left
        tbl.push_back('{1,  300, 100, 100, 300, 2, 0, 8'h00, 1}); // lost alignment
        tbl.push_back('{1,  300, 100, 100, 300, 2, 0, 8'h04, 1}); // tie 200/200 -> X left
        tbl.push_back('{1,  300, 100, 300,  50, 1, 1, 8'h00, 2}); // column aligned
        tbl.push_back('{1,  300, 100, 300,  50, 1, 1, 8'h2C, 3}); // up matches, stale bullet
        tbl.push_back('{1,  300, 100, 300,  50, 1, 1, 8'h00, 4}); // stale bullet ends shot
        tbl.push_back('{59, 300, 100, 300,  50, 1, 0, 8'h00, 4});
        tbl.push_back('{1,  300, 100, 300,  50, 1, 0, 8'h00, 1});
        tbl.push_back('{1,  300, 100, 300,  50, 1, 0, 8'h00, 2});
        tbl.push_back('{1,  300, 100, 300,  50, 1, 0, 8'h2C, 3}); // in FIRE for disable test

        repeat (3) @(negedge Clk);
        chk_out("reset", 8'h00, 3'd0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        foreach (tbl[i]) begin
            set_pos(tbl[i].sx, tbl[i].sy, tbl[i].tx, tbl[i].ty, tbl[i].dir, tbl[i].hit);
            frames(tbl[i].nfr);
            chk_out($sformatf("vec%0d", i), tbl[i].key, tbl[i].st);
        end

        // disable mid-FIRE acts on the next Clk, no frame needed
        @(negedge Clk) bus.ai_en = 1'b0;
        @(negedge Clk);
        chk_out("disable", 8'h00, 3'd0);
        frames(2);
        chk_out("disable_hold", 8'h00, 3'd0);
        bus.ai_en = 1'b1;
        frames(29);
        chk_out("reenable_29", 8'h00, 3'd0);
        frames(1);
        chk_out("reenable_30", 8'h00, 3'd1);

        // frame_clk held high: one update only
        set_pos(10'd100, 10'd100, 10'd300, 10'd150, 3'd1, 2'd0);
        @(negedge Clk) bus.frame_clk = 1'b1;
        repeat (1000) @(negedge Clk);
        chk_out("hold_high", 8'h16, 3'd1);
        bus.target_X = 10'd120; bus.target_Y = 10'd400;
        repeat (100) @(negedge Clk);
        chk_out("hold_high_noupd", 8'h16, 3'd1);
        bus.frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        frames(1);
        chk_out("after_hold", 8'h07, 3'd1);

        // async reset between edges
        bus.target_X = 10'd102; bus.target_Y = 10'd300;
        frames(1);
        chk_out("pre_reset_aim", 8'h00, 3'd2);
        frames(1);
        chk_out("pre_reset_turn", 8'h16, 3'd2);
        @(negedge Clk);
        #3 Reset = 1'b1;
        #1;
        chk_out("async_reset", 8'h00, 3'd0);
        @(negedge Clk) Reset = 1'b0;
        repeat (2) @(negedge Clk);

`ifdef ENEMY_AI_WANDER_EN
        begin
            logic [15:0] m;
            m = 16'hACE1;
            for (int i = 0; i < 30; i++) begin
                frames(1);
                chk($sformatf("wander%0d", i), bus.keycode, wkey(m[1:0]));
                m = lfsr_step(m);
            end
        end
`else
        frames(5);
        chk_out("idle_after_reset", 8'h00, 3'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
